// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives master, adder sits on slave.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder stage per cycle, LSB first, WIDTH cycles per add.
// Result, carry and signed overflow are published together on the single-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  serial_adder_if.slave  io_bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sum_bit;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  always_comb begin
    w_sum_bit    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    w_carry_next = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
    w_res_next   = {w_sum_bit, r_res_sh[WIDTH-1:1]};
    w_last       = (r_cnt == CntW'(WIDTH - 1));
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.start) w_state_next = StAdd;
      StAdd:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_a_sh   <= io_bus.a;
            r_b_sh   <= io_bus.b;
            r_carry  <= io_bus.cin;
            r_res_sh <= '0;
            r_cnt    <= '0;
          end
        end
        StAdd: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_next;
          r_carry  <= w_carry_next;
          r_cnt    <= r_cnt + 1'b1;
          // On the MSB stage r_carry is the carry into the MSB, so ovf = c_in(msb) ^ c_out(msb)
          if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_carry_next;
            r_ovf  <= r_carry ^ w_carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.ready = (r_state == StIdle);
  assign io_bus.busy  = (r_state == StAdd);
  assign io_bus.done  = (r_state == StDone);
  assign io_bus.sum   = r_sum;
  assign io_bus.cout  = r_cout;
  assign io_bus.ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 instance for directed/random/corner cases,
// WIDTH=2 instance for the exhaustive back-to-back sweep.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(2)) if2 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (if8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_add(input int w, input int a, input int b, input int c,
                                  output int s, output int co, output int ov);
    int full;
    int sa;
    int sb;
    int sv;
    full = a + b + c;
    s    = full % (1 << w);
    co   = (full >= (1 << w)) ? 1 : 0;
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sv   = sa + sb + c;
    ov   = (sv >= (1 << (w - 1)) || sv < -(1 << (w - 1))) ? 1 : 0;
  endfunction

  // Launch one WIDTH=8 add and observe 14 cycles after acceptance.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co, output logic ov,
                      output int lat, output int busy_n, output int done_n, output bit moved);
    logic [7:0] held;
    int wt;
    wt = 0;
    while (if8.ready !== 1'b1 && wt < 20) begin
      tick();
      wt++;
    end
    held   = if8.sum;
    s      = 8'hxx;
    co     = 1'bx;
    ov     = 1'bx;
    lat    = 0;
    busy_n = 0;
    done_n = 0;
    moved  = 1'b0;
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    if8.cin   = c;
    tick();
    if8.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (if8.busy === 1'b1) begin
        busy_n++;
        if (if8.sum !== held) moved = 1'b1;
      end
      if (if8.done === 1'b1) begin
        done_n++;
        if (lat == 0) begin
          lat = k;
          s   = if8.sum;
          co  = if8.cout;
          ov  = if8.ovf;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (if8.ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready got %b want 1", if8.ready);
    end
    n_checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy_done got %b%b want 00", if8.busy, if8.done);
    end
    n_checks++;
    if (if8.sum !== 8'h00 || if8.cout !== 1'b0 || if8.ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_result got sum=%h cout=%b ovf=%b want 00/0/0",
               if8.sum, if8.cout, if8.ovf);
    end
    n_checks++;
    if (if2.ready !== 1'b1 || if2.sum !== 2'b00) begin
      n_errors++; $display("FAIL reset_w2 got ready=%b sum=%b want 1/00", if2.ready, if2.sum);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic c);
    logic [7:0] s;
    logic co;
    logic ov;
    int lat, busy_n, done_n, es, eco, eov;
    bit moved;
    ref_add(8, int'(a), int'(b), int'(c), es, eco, eov);
    run8(a, b, c, s, co, ov, lat, busy_n, done_n, moved);
    n_checks++;
    if (s !== 8'(es) || co !== 1'(eco) || ov !== 1'(eov)) begin
      n_errors++;
      $display("FAIL %s_result a=%h b=%h cin=%b got sum=%h cout=%b ovf=%b want %h/%0d/%0d",
               name, a, b, c, s, co, ov, es, eco, eov);
    end
    n_checks++;
    if (lat != 9) begin
      n_errors++; $display("FAIL %s_latency got %0d want 9", name, lat);
    end
    n_checks++;
    if (busy_n != 8 || done_n != 1) begin
      n_errors++; $display("FAIL %s_pulses got busy=%0d done=%0d want 8/1", name, busy_n, done_n);
    end
    n_checks++;
    if (moved) begin
      n_errors++; $display("FAIL %s_partial got sum changing during add want stable", name);
    end
    n_checks++;
    if (if8.sum !== 8'(es) || if8.ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_hold got sum=%h ready=%b want %h/1", name, if8.sum, if8.ready, es);
    end
  endtask

  task automatic test_directed();
    check_op8("zero", 8'h00, 8'h00, 1'b0);
    check_op8("wrap", 8'hFF, 8'h01, 1'b0);
    check_op8("ovf", 8'h7F, 8'h01, 1'b0);
    check_op8("cin", 8'hA5, 8'h5A, 1'b1);
    check_op8("neg_ovf", 8'h80, 8'hFF, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      check_op8("rand", 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_ignore_start();
    int busy_n, done_n;
    logic [7:0] s;
    s = 8'hxx;
    busy_n = 0;
    done_n = 0;
    if8.start = 1'b1;
    if8.a     = 8'h10;
    if8.b     = 8'h20;
    if8.cin   = 1'b0;
    tick();
    if8.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 2) begin
        if8.a     = 8'hFF;
        if8.b     = 8'hFF;
        if8.start = 1'b1;
      end
      if (k == 3) if8.start = 1'b0;
      if (if8.busy === 1'b1) busy_n++;
      if (if8.done === 1'b1) begin
        done_n++;
        s = if8.sum;
        if8.start = 1'b1;  // sampled only in DONE, must be ignored
      end else if (k > 3) begin
        if8.start = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (s !== 8'h30) begin
      n_errors++; $display("FAIL ignore_sum got %h want 30", s);
    end
    n_checks++;
    if (done_n != 1 || busy_n != 8) begin
      n_errors++; $display("FAIL ignore_single got done=%0d busy=%0d want 1/8", done_n, busy_n);
    end
  endtask

  task automatic test_reset_abort();
    int done_n;
    logic [7:0] s;
    logic co, ov;
    int lat, busy_n, dn;
    bit moved;
    check_op8("pre_abort", 8'h12, 8'h34, 1'b1);
    if8.start = 1'b1;
    if8.a     = 8'hC3;
    if8.b     = 8'h3C;
    if8.cin   = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (if8.busy !== 1'b1) begin
      n_errors++; $display("FAIL abort_in_add got busy=%b want 1", if8.busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (if8.ready !== 1'b1 || if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.sum !== 8'h00 ||
        if8.cout !== 1'b0 || if8.ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_state got ready=%b busy=%b done=%b sum=%h cout=%b ovf=%b want 1/0/0/00/0/0",
               if8.ready, if8.busy, if8.done, if8.sum, if8.cout, if8.ovf);
    end
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (if8.done === 1'b1) done_n++;
      tick();
    end
    n_checks++;
    if (done_n != 0) begin
      n_errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_n);
    end
    run8(8'h03, 8'h04, 1'b0, s, co, ov, lat, busy_n, dn, moved);
    n_checks++;
    if (s !== 8'h07 || lat != 9) begin
      n_errors++; $display("FAIL abort_resume got sum=%h lat=%0d want 07/9", s, lat);
    end
  endtask

  task automatic test_back_to_back();
    int prev_done, have_prev, wt, k, ai, bi, ci, es, eco, eov;
    have_prev = 0;
    prev_done = 0;
    if2.start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ai = (i >> 3) & 3;
      bi = (i >> 1) & 3;
      ci = i & 1;
      ref_add(2, ai, bi, ci, es, eco, eov);
      wt = 0;
      while (if2.ready !== 1'b1 && wt < 10) begin
        tick();
        wt++;
      end
      if2.a   = 2'(ai);
      if2.b   = 2'(bi);
      if2.cin = 1'(ci);
      tick();
      k = 1;
      while (if2.done !== 1'b1 && k < 8) begin
        tick();
        k++;
      end
      n_checks++;
      if (if2.done !== 1'b1 || k != 3) begin
        n_errors++; $display("FAIL b2b_latency case %0d got %0d want 3", i, k);
      end
      n_checks++;
      if (if2.sum !== 2'(es) || if2.cout !== 1'(eco) || if2.ovf !== 1'(eov)) begin
        n_errors++;
        $display("FAIL b2b_result case %0d got sum=%b cout=%b ovf=%b want %0d/%0d/%0d",
                 i, if2.sum, if2.cout, if2.ovf, es, eco, eov);
      end
      if (have_prev != 0) begin
        n_checks++;
        if (cyc - prev_done != 4) begin
          n_errors++; $display("FAIL b2b_spacing case %0d got %0d want 4", i, cyc - prev_done);
        end
      end
      have_prev = 1;
      prev_done = cyc;
    end
    if2.start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    if8.start = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if8.cin   = 1'b0;
    if2.start = 1'b0;
    if2.a     = '0;
    if2.b     = '0;
    if2.cin   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
